// File: rtl/shift_register_ctrl_if.sv
// Word-producer handshake into the shift register controller: one word plus
// its shift direction and fill bit, transferred on valid && ready.
interface shift_register_ctrl_if #(
    parameter int N = 8
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         s_dir;
    logic         s_fill;

    modport master (
        output s_valid,
        output s_data,
        output s_dir,
        output s_fill,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_dir,
        input  s_fill,
        output s_ready
    );
endinterface

// File: rtl/shift_register_ctrl.sv
// Sequencer for an external Shift_Register: loads one accepted word, tracks the
// N shift cycles that carry frame bits, and pulses done at the end of the frame.
module shift_register_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_register_ctrl_if.slave s,
    input  logic                 abort,
    output logic                 sr_load,
    output logic [N-1:0]         sr_din,
    output logic                 sr_dir,
    output logic                 sr_rin,
    input  logic [N-1:0]         sr_q,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N-1:0]     hold_data;
    logic             hold_dir;
    logic             hold_fill;
    logic             accept;

    // Exiting bit sits at the end the register shifts away from.
    function automatic logic exit_bit(input logic [N-1:0] q, input logic dir);
        return dir ? q[N-1] : q[0];
    endfunction

    assign accept = (state_q == IDLE) && s.s_valid;

    // State, counter and holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_data <= '0;
            hold_dir  <= 1'b0;
            hold_fill <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                hold_data <= s.s_data;
                hold_dir  <= s.s_dir;
                hold_fill <= s.s_fill;
            end
        end
    end

    // Next-state decode; abort outranks the final-bit transition to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (s.s_valid) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        s.s_ready = (state_q == IDLE);
        sr_load   = (state_q == LOAD);
        ser_valid = (state_q == SHIFT);
        done      = (state_q == DONE);
        busy      = (state_q != IDLE);
        sr_din    = hold_data;
        sr_dir    = hold_dir;
        sr_rin    = hold_fill;
        ser_out   = exit_bit(sr_q, hold_dir);
    end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench for shift_register_ctrl with a behavioural Shift_Register and
// a queue of expected serial bits checked whenever ser_valid is high.
module tb_shift_register_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         abort;
    logic         sr_load;
    logic [N-1:0] sr_din;
    logic         sr_dir;
    logic         sr_rin;
    logic [N-1:0] sr_q = '0;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_done   = 0;
    int n_load   = 0;
    int cyc      = 0;

    logic exp_q[$];

    shift_register_ctrl_if #(.N(N)) bus ();

    shift_register_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .abort     (abort),
        .sr_load   (sr_load),
        .sr_din    (sr_din),
        .sr_dir    (sr_dir),
        .sr_rin    (sr_rin),
        .sr_q      (sr_q),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Shift_Register: shifts on every non-load cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sr_load)     sr_q <= sr_din;
        else if (sr_dir) sr_q <= {sr_q[N-2:0], sr_rin};
        else             sr_q <= {sr_rin, sr_q[N-1:1]};
    end

    always @(negedge clk) begin
        if (ser_valid) begin
            n_valid++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL ser_unexpected observed=%0b required=no frame bit", ser_out);
            end else begin
                automatic logic e = exp_q.pop_front();
                assert (ser_out === e) else begin
                    n_fail++;
                    $error("FAIL ser_out observed=%0b required=%0b", ser_out, e);
                end
            end
        end
        if (done)    n_done++;
        if (sr_load) n_load++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // Drives one word from a fresh cycle; returns 1 time unit into the LOAD cycle.
    task automatic send(input logic [N-1:0] d, input logic dr, input logic f);
        bit got = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_q.push_back(dr ? d[N-1-i] : d[i]);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_dir   = dr;
        bus.s_fill  = f;
        for (int t = 0; t < 40 && !got; t++) begin
            smp();
            if (bus.s_ready) got = 1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $error("FAIL ready_timeout observed=0 required=1");
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    // Checks a complete frame that started with LOAD in the current cycle.
    task automatic frame_body(input logic f);
        int d0 = n_done;
        int l0 = n_load;
        smp();
        chk("load_pulse", sr_load, 1'b1);
        chk("load_busy", busy, 1'b1);
        chk("load_ready", bus.s_ready, 1'b0);
        repeat (N) smp();
        chk("no_early_done", n_done - d0, 0);
        smp();
        chk("done_pulse", done, 1'b1);
        chk("sr_q_filled", sr_q, {N{f}});
        chk("bits_consumed", exp_q.size(), 0);
        smp();
        chk("done_once", n_done - d0, 1);
        chk("load_once", n_load - l0, 1);
        chk("ready_again", bus.s_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int v0;
        int d0;
        int rdy;
        int t0;
        int t1;

        rst         = 1'b1;
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_dir   = 1'b0;
        bus.s_fill  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.s_ready, 1'b1);
        chk("rst_load", sr_load, 1'b0);
        chk("rst_din", sr_din, 0);
        chk("rst_dir", sr_dir, 1'b0);
        chk("rst_rin", sr_rin, 1'b0);
        chk("rst_ser_out", ser_out, sr_q[0]);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // MSB first, fill 1
        send(8'b0000_0011, 1'b1, 1'b1);
        frame_body(1'b1);

        // LSB first, fill 0
        send(8'b0000_0011, 1'b0, 1'b0);
        frame_body(1'b0);

        // s_valid held high across two words
        @(posedge clk);
        #1;
        d0 = n_done;
        for (int i = 0; i < N; i++) exp_q.push_back(8'hA5 >> (N - 1 - i));
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.s_dir   = 1'b1;
        bus.s_fill  = 1'b0;
        smp();
        chk("b2b_ready_first", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.s_data = 8'h3C;
        for (int i = 0; i < N; i++) exp_q.push_back(8'h3C >> (N - 1 - i));
        rdy = 0;
        repeat (N + 2) begin
            smp();
            if (bus.s_ready) rdy++;
        end
        chk("b2b_ready_low", rdy, 0);
        smp();
        chk("b2b_ready_second", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        t1 = cyc;
        bus.s_valid = 1'b0;
        chk("b2b_spacing", t1 - t0, N + 3);
        chk("b2b_first_done", n_done - d0, 1);
        frame_body(1'b0);

        // abort during the 4th SHIFT cycle
        send(8'h5A, 1'b1, 1'b0);
        v0 = n_valid;
        d0 = n_done;
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        smp();
        chk("abort_idle", bus.s_ready, 1'b1);
        chk("abort_ser_valid", ser_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_bits", n_valid - v0, 4);
        chk("abort_left", exp_q.size(), 4);
        exp_q.delete();
        repeat (3) smp();
        chk("abort_no_done", n_done - d0, 0);
        send(8'hC3, 1'b0, 1'b1);
        frame_body(1'b1);

        // reset during the 5th SHIFT cycle
        send(8'h96, 1'b1, 1'b1);
        v0 = n_valid;
        d0 = n_done;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_ready", bus.s_ready, 1'b1);
        chk("mrst_load", sr_load, 1'b0);
        chk("mrst_din", sr_din, 0);
        chk("mrst_dir", sr_dir, 1'b0);
        chk("mrst_rin", sr_rin, 1'b0);
        chk("mrst_ser_out", ser_out, sr_q[0]);
        chk("mrst_ser_valid", ser_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_bits", n_valid - v0, 4);
        chk("mrst_left", exp_q.size(), 4);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        smp();
        chk("mrst_release_ready", bus.s_ready, 1'b1);
        chk("mrst_no_done", n_done - d0, 0);
        send(8'h81, 1'b1, 1'b1);
        frame_body(1'b1);

        // abort together with the last bit
        send(8'hE7, 1'b0, 1'b1);
        v0 = n_valid;
        d0 = n_done;
        repeat (N) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        smp();
        chk("lastabort_done", done, 1'b0);
        chk("lastabort_idle", bus.s_ready, 1'b1);
        chk("lastabort_busy", busy, 1'b0);
        chk("lastabort_bits", n_valid - v0, N);
        chk("lastabort_left", exp_q.size(), 0);
        repeat (3) smp();
        chk("lastabort_no_done", n_done - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_register_ctrl.md
# shift_register_ctrl

Sequencing controller for the parameterised `Shift_Register` datapath. It accepts a parallel word plus a shift direction and fill bit over a valid/ready handshake. It then loads the word into the shift register and counts exactly N shift cycles, presenting each exiting bit as a serial output with a valid strobe, and pulses `done` at the end of the frame. It sits between a word producer and the shift register and owns all of the register's control inputs (`load`, `dir`, `rin`, `din`).

## Interface
- `N`, default 8: word width and number of shift cycles per frame; N >= 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  producer has a word.
- `s_ready`  out  1  controller can accept a word.
- `s_data`  in  N  word to serialise.
- `s_dir`  in  1  1 = shift left (MSB first), 0 = shift right (LSB first).
- `s_fill`  in  1  bit shifted in at the vacated end.
- `abort`  in  1  cancels the current frame.
- `sr_load`  out  1  to `Shift_Register.load`.
- `sr_din`  out  N  to `Shift_Register.din`.
- `sr_dir`  out  1  to `Shift_Register.dir`.
- `sr_rin`  out  1  to `Shift_Register.rin`.
- `sr_q`  in  N  from `Shift_Register.q`.
- `ser_out`  out  1  bit currently leaving the register.
- `ser_valid`  out  1  `ser_out` is a frame bit.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle end-of-frame pulse.

## Operation
- Shift register contract:
  - When `load` is high, q <= din.
  - Otherwise, if dir=1, q <= {q[N-2:0], rin}; if dir=0, q <= {rin, q[N-1:1]}.
  - The register shifts on every non-load cycle. The controller only tracks which cycles are frame bits.
- FSM states: IDLE, LOAD, SHIFT, DONE. Counter `cnt` is $clog2(N) bits wide.
- IDLE:
  - `s_ready`=1.
  - On `s_valid`&&`s_ready`, capture `s_data`, `s_dir` and `s_fill` into holding registers and go to LOAD.
- LOAD:
  - `sr_load`=1, `sr_din`=captured data.
  - Set `cnt` to 0 and go to SHIFT.
- SHIFT:
  - `ser_valid`=1.
  - `ser_out` = `sr_q[N-1]` if captured dir=1, otherwise `sr_q[0]`.
  - If `cnt`==N-1, go to DONE; otherwise increment `cnt`.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `sr_dir` and `sr_rin` always drive the captured dir and fill. They are unchanged in IDLE and DONE, so the register keeps shifting harmlessly.
- `sr_din` always drives the captured data.
- `busy`=1 in LOAD, SHIFT and DONE.
- `s_ready` = (state==IDLE). `s_valid` is ignored outside IDLE and nothing is queued.
- `abort`:
  - Sampled in LOAD or SHIFT. It forces IDLE on the next edge; `done` is not pulsed and `ser_valid` drops.
  - In IDLE or DONE, `abort` has no effect. DONE still pulses.
- If `abort` and `cnt`==N-1 occur in SHIFT in the same cycle, abort wins and there is no `done`.
- Holding registers are not modified outside an IDLE handshake.

## Timing
- Reset values (asynchronous, applied immediately and held while `rst`=1):
  - state=IDLE, `cnt`=0, holding registers=0.
  - `s_ready`=1, `sr_load`=0, `sr_din`=0, `sr_dir`=0, `sr_rin`=0.
  - `ser_out`=`sr_q[0]`, `ser_valid`=0, `busy`=0, `done`=0.
- Reset mid-frame returns to IDLE instantly. No `done` pulse; the frame is lost.
- All outputs are decoded from registered state and holding registers. No input-to-output combinational paths exist except `sr_q`->`ser_out`.
- Frame timing for a handshake at edge k:
  - Cycle k+1 is LOAD.
  - Cycles k+2 through k+N+1 are the N SHIFT bits.
  - Cycle k+N+2 is DONE.
  - `s_ready`=1 again at cycle k+N+3.
- Throughput is N+3 cycles per word. Back-to-back frames need no idle gap beyond the IDLE cycle.
- After a frame of N shifts, `sr_q` = {N{fill}}. The bench checks this one cycle after the last SHIFT (during DONE).

## Test plan
- Reset, then N=8, `s_data`=8'b00000011, dir=1, fill=1 -> one `sr_load` pulse; `ser_out` = 0,0,0,0,0,0,1,1 over 8 `ser_valid` cycles; `done` at handshake+10; `sr_q`=8'hFF during DONE.
- Same word, dir=0, fill=0 -> `ser_out` = 1,1,0,0,0,0,0,0; `sr_q`=8'h00 during DONE.
- `s_valid` held high continuously with words 8'hA5 then 8'h3C -> accepted 11 cycles apart; `s_ready` low throughout the first frame; serial streams are 10100101 then 00111100 (dir=1).
- `abort` in the 4th SHIFT cycle -> IDLE next cycle; exactly 4 `ser_valid` bits; no `done`; the next word frames correctly.
- `rst` asserted mid-SHIFT at bit 5 -> all outputs at reset values immediately; after release, `s_ready`=1 and a new frame completes normally.
- `abort` coincident with the last bit -> no `done`, state IDLE.
